// File: rtl/bbox_pixel_scanner_pkg.sv
// Shared types and constants for the bounding-box pixel scanner.
// Holds frame geometry, coordinate types and small helper functions.
package bbox_pixel_scanner_pkg;

    localparam int FRAME_WIDTH  = 512;
    localparam int FRAME_HEIGHT = 384;
    localparam int COORD_BITS   = 16;
    localparam int ADDR_BITS    = 18;
    localparam int TRI_BITS     = 6 * COORD_BITS;

    typedef logic signed [COORD_BITS-1:0] coord_t;
    typedef logic [ADDR_BITS-1:0]         addr_t;

    // x0 occupies the MSBs, matching the tri_in bus layout
    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        coord_t x2;
        coord_t y2;
    } screen_tri_t;

    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
    } bbox_t;

    localparam coord_t ZERO   = '0;
    localparam coord_t X_LAST = coord_t'(FRAME_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(FRAME_HEIGHT - 1);

    function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // FRAME_WIDTH*v + h built as a sum of shifted copies of v,
    // one per set bit of the constant width
    function automatic addr_t pix_addr_of(coord_t h, coord_t v);
        addr_t acc;
        acc = addr_t'(h);
        for (int i = 0; i < ADDR_BITS; i++) begin
            if (FRAME_WIDTH[i]) acc = acc + (addr_t'(v) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bbox_pixel_scanner_if.sv
// Triangle-in / pixel-out bus of the bounding-box pixel scanner.
// slave: the scanner side; master: the upstream/downstream side.
interface bbox_pixel_scanner_if;
    import bbox_pixel_scanner_pkg::*;

    logic                  tri_valid;
    logic                  tri_ready;
    logic [TRI_BITS-1:0]   tri_in;
    logic [15:0]           tri_color;
    logic [TRI_BITS-1:0]   tri_out;
    logic                  tri_out_valid;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [COORD_BITS-1:0] hcount;
    logic [COORD_BITS-1:0] vcount;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic [15:0]           pix_color;
    logic                  pix_last;
    logic                  done;
    logic                  culled;

    modport slave (
        input  tri_valid, tri_in, tri_color, pix_ready,
        output tri_ready, tri_out, tri_out_valid,
        output pix_valid, hcount, vcount, pix_addr,
        output pix_color, pix_last, done, culled
    );

    modport master (
        output tri_valid, tri_in, tri_color, pix_ready,
        input  tri_ready, tri_out, tri_out_valid,
        input  pix_valid, hcount, vcount, pix_addr,
        input  pix_color, pix_last, done, culled
    );

endinterface

// File: rtl/bbox_pixel_scanner_bbox_calc.sv
// Combinational bounding box of a triangle, clamped to the frame.
// In: vtx (triangle). Out: box (clamped bounds), cull (fully off-screen).
module bbox_calc
    import bbox_pixel_scanner_pkg::*;
(
    input  screen_tri_t vtx,
    output bbox_t       box,
    output logic        cull
);

    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;

    always_comb begin
        xmin = min3(vtx.x0, vtx.x1, vtx.x2);
        xmax = max3(vtx.x0, vtx.x1, vtx.x2);
        ymin = min3(vtx.y0, vtx.y1, vtx.y2);
        ymax = max3(vtx.y0, vtx.y1, vtx.y2);

        cull = (xmax < ZERO) || (xmin > X_LAST) ||
               (ymax < ZERO) || (ymin > Y_LAST);

        // only meaningful when not culled
        box.xmin = (xmin < ZERO)   ? ZERO   : xmin;
        box.ymin = (ymin < ZERO)   ? ZERO   : ymin;
        box.xmax = (xmax > X_LAST) ? X_LAST : xmax;
        box.ymax = (ymax > Y_LAST) ? Y_LAST : ymax;
    end

endmodule

// File: rtl/bbox_pixel_scanner.sv
// Takes one triangle, bounds and clamps it, then streams the box pixels.
// Ports: clk, rst_n (async, active-low), bus (triangle in, pixels out).
module bbox_pixel_scanner
    import bbox_pixel_scanner_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    bbox_pixel_scanner_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BOUND = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;

    logic [1:0]  state;
    screen_tri_t tri_q;
    logic [15:0] color_q;
    coord_t      xmin_q;
    coord_t      xmax_q;
    coord_t      ymax_q;
    coord_t      hcount;
    coord_t      vcount;
    addr_t       pix_addr;
    logic        last_q;
    logic        tov_r;
    logic        done_r;
    logic        culled_r;

    bbox_t  box;
    logic   cull;
    logic   at_xend;
    logic   at_end;
    coord_t h_nxt;
    coord_t v_nxt;

    bbox_calc u_calc (
        .vtx  (tri_q),
        .box  (box),
        .cull (cull)
    );

    always_comb begin
        at_xend = (hcount == xmax_q);
        at_end  = at_xend && (vcount == ymax_q);
        h_nxt   = at_xend ? xmin_q : hcount + coord_t'(1);
        v_nxt   = at_xend ? vcount + coord_t'(1) : vcount;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tri_q    <= '0;
            color_q  <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymax_q   <= '0;
            hcount   <= '0;
            vcount   <= '0;
            pix_addr <= '0;
            last_q   <= 1'b0;
            tov_r    <= 1'b0;
            done_r   <= 1'b0;
            culled_r <= 1'b0;
        end else begin
            tov_r    <= 1'b0;
            done_r   <= 1'b0;
            culled_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.tri_valid) begin
                        tri_q   <= screen_tri_t'(bus.tri_in);
                        color_q <= bus.tri_color;
                        state   <= S_BOUND;
                    end
                end
                S_BOUND: begin
                    if (cull) begin
                        done_r   <= 1'b1;
                        culled_r <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        xmin_q   <= box.xmin;
                        xmax_q   <= box.xmax;
                        ymax_q   <= box.ymax;
                        hcount   <= box.xmin;
                        vcount   <= box.ymin;
                        pix_addr <= pix_addr_of(box.xmin, box.ymin);
                        last_q   <= (box.xmin == box.xmax) &&
                                    (box.ymin == box.ymax);
                        tov_r    <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (bus.pix_ready) begin
                        if (at_end) begin
                            done_r <= 1'b1;
                            last_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            hcount   <= h_nxt;
                            vcount   <= v_nxt;
                            pix_addr <= pix_addr_of(h_nxt, v_nxt);
                            last_q   <= (h_nxt == xmax_q) &&
                                        (v_nxt == ymax_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ready is forced low while reset is held, not just after it
    assign bus.tri_ready     = (state == S_IDLE) && rst_n;
    assign bus.tri_out       = tri_q;
    assign bus.tri_out_valid = tov_r;
    assign bus.pix_valid     = (state == S_SCAN);
    assign bus.hcount        = hcount;
    assign bus.vcount        = vcount;
    assign bus.pix_addr      = pix_addr;
    assign bus.pix_color     = color_q;
    assign bus.pix_last      = last_q && (state == S_SCAN);
    assign bus.done          = done_r;
    assign bus.culled        = culled_r;

endmodule
